// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Register offsets, STATUS bit positions and serialiser state encoding.
package uart_tx_pkg;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    function automatic logic [3:0] sat_count(input logic [31:0] n);
        return (n > 32'd15) ? 4'hF : n[3:0];
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Processor data-bus slice seen by a memory-mapped peripheral.
interface mmio_bus_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output mem_write, input rdata);
    modport slave  (input addr, input wdata, input mem_write, output rdata);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, registers, TX FIFO,
// baud down-counter and serialiser FSM.
//
//   state | meaning
//   IDLE  | line high, waiting for a byte in the FIFO
//   START | start bit (low) for one bit period
//   DATA  | data bits, LSB first, idx selects the bit
//   STOP  | stop bit (high); pops the next byte back-to-back if present
module mmio_uart_tx
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic      clk,
    input  logic      reset,
    mmio_bus_if.slave bus,
    output logic      tx,
    output logic      tx_idle
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel;
    logic [1:0]    off;
    logic          wr_txdata;
    logic          wr_status;
    logic          wr_baud;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic          overflow;
    logic [15:0]   div;
    logic [31:0]   rdata_c;
    logic          unused_bits;

    tx_state_t     state, state_n;
    logic [15:0]   cnt, cnt_n;
    logic [15:0]   per, per_n;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    idx, idx_n;
    logic          tx_q, tx_n;
    logic          start_frame;

    assign sel       = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign off       = bus.addr[3:2];
    assign wr_txdata = sel & bus.mem_write & (off == OFF_TXDATA);
    assign wr_status = sel & bus.mem_write & (off == OFF_STATUS);
    assign wr_baud   = sel & bus.mem_write & (off == OFF_BAUDDIV);
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:16]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .pop   (pop),
        .din   (bus.wdata[7:0]),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            div      <= DIV_RESET;
        end else begin
            if (wr_baud) div <= (bus.wdata[15:0] < 16'd2) ? 16'd2 : bus.wdata[15:0];
            // a dropped push outranks a concurrent clear
            if (wr_txdata && fifo_full && !pop)       overflow <= 1'b1;
            else if (wr_status && bus.wdata[ST_OVF])  overflow <= 1'b0;
        end
    end

    always_comb begin
        rdata_c = '0;
        if (sel) begin
            case (off)
                OFF_STATUS: begin
                    rdata_c[ST_BUSY]          = (state != IDLE);
                    rdata_c[ST_FULL]          = fifo_full;
                    rdata_c[ST_EMPTY]         = fifo_empty;
                    rdata_c[ST_OVF]           = overflow;
                    rdata_c[ST_CNT_LSB +: 4]  = sat_count(32'(fifo_count));
                end
                OFF_BAUDDIV: rdata_c[15:0] = div;
                default: ;
            endcase
        end
    end
    assign bus.rdata = rdata_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            per   <= '0;
            shreg <= '0;
            idx   <= '0;
            tx_q  <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            per   <= per_n;
            shreg <= shreg_n;
            idx   <= idx_n;
            tx_q  <= tx_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        per_n       = per;
        shreg_n     = shreg;
        idx_n       = idx;
        tx_n        = tx_q;
        pop         = 1'b0;
        start_frame = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!fifo_empty) start_frame = 1'b1;
            end
            START: begin
                if (cnt == '0) begin
                    state_n = DATA;
                    idx_n   = '0;
                    cnt_n   = per - 16'd1;
                    tx_n    = shreg[0];
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    cnt_n = per - 16'd1;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        idx_n = idx + 3'd1;
                        tx_n  = shreg[idx + 3'd1];
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                    if (!fifo_empty) start_frame = 1'b1;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
        // divider sampled only here so BAUDDIV writes never touch a running frame
        if (start_frame) begin
            pop     = 1'b1;
            shreg_n = fifo_head;
            per_n   = div;
            cnt_n   = div - 16'd1;
            state_n = START;
            tx_n    = 1'b0;
        end
    end

    assign tx      = tx_q;
    assign tx_idle = fifo_empty & (state == IDLE);
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboarded bench for mmio_uart_tx: a frame-schedule model predicts every
// serial frame and register read; a line monitor decodes tx and compares.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 8;

    typedef struct {
        int         pop;
        int         fin;
        logic [7:0] data;
        int         div;
    } frame_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx;
    logic tx_idle;

    mmio_bus_if bus();

    mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .tx      (tx),
        .tx_idle (tx_idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    frame_t sched[$];
    frame_t exp_q[$];
    int     last_end;
    int     m_div;
    bit     m_ovf;
    int     n_vec = 0;
    int     n_err = 0;
    int     frames_seen = 0;
    bit     mon_busy = 0;
    int     wr_edge;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: schedule of frames in edge numbers
    task automatic m_reset();
        sched.delete();
        exp_q.delete();
        last_end = 0;
        m_div    = 434;
        m_ovf    = 0;
    endtask

    function automatic int m_occ(input int e);
        int n = 0;
        foreach (sched[i]) if (sched[i].pop > e) n++;
        return n;
    endfunction

    function automatic bit m_busy(input int e);
        foreach (sched[i]) if (sched[i].pop <= e && e < sched[i].fin) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_idle(input int e);
        return (!m_busy(e) && m_occ(e) == 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input int e);
        logic [31:0] s = '0;
        int occ;
        if (a[31:4] != BASE[31:4]) return 32'h0;
        case (a[3:2])
            2'd1: begin
                occ  = m_occ(e);
                s[0] = m_busy(e);
                s[1] = (occ == DEPTH);
                s[2] = (occ == 0);
                s[3] = m_ovf;
                s[7:4] = (occ > 15) ? 4'hF : 4'(occ);
                return s;
            end
            2'd2: return 32'(m_div);
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- bus tasks
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        frame_t f;
        int e;
        @(negedge clk);
        bus.addr = a;
        bus.wdata = d;
        bus.mem_write = 1'b1;
        e = cyc + 1;
        wr_edge = e;
        if (a[31:4] == BASE[31:4]) begin
            case (a[3:2])
                2'd0: begin
                    if (m_occ(e) < DEPTH) begin
                        f.pop  = (e + 1 > last_end) ? e + 1 : last_end;
                        f.fin  = f.pop + 10 * m_div;
                        f.data = d[7:0];
                        f.div  = m_div;
                        last_end = f.fin;
                        sched.push_back(f);
                        exp_q.push_back(f);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                2'd1: if (d[3]) m_ovf = 1'b0;
                2'd2: m_div = (d[15:0] < 16'd2) ? 2 : int'(d[15:0]);
                default: ;
            endcase
        end
        @(posedge clk);
        #1 bus.mem_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input string name, output logic [31:0] v);
        @(negedge clk);
        bus.addr = a;
        bus.mem_write = 1'b0;
        #1;
        v = bus.rdata;
        chk(name, v, m_read(a, cyc));
    endtask

    task automatic wait_to(input int c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc < c && n < 20000);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cyc >= last_end && !mon_busy && exp_q.size() == 0) && n < 20000);
        if (n >= 20000) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d frames outstanding, required 0", exp_q.size());
        end
        chk("idle_tx_idle", tx_idle, m_idle(cyc));
        chk("idle_tx_high", tx, 1'b1);
    endtask

    // ---------------- line monitor
    initial begin : monitor
        frame_t     f;
        logic [7:0] got;
        int         bad, nb, j;
        bit         aborted;
        logic       expb;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                mon_busy = 1;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
                    nb = 0;
                    while (tx_idle !== 1'b1 && nb < 20000) begin
                        @(negedge clk);
                        nb++;
                    end
                end else begin
                    f = exp_q.pop_front();
                    chk("frame_start_cycle", cyc, f.pop);
                    got = '0;
                    bad = 0;
                    aborted = 0;
                    for (int k = 0; k < 10 * f.div; k++) begin
                        if (k > 0) @(negedge clk);
                        if (reset !== 1'b1) begin
                            aborted = 1;
                            break;
                        end
                        j = k / f.div;
                        expb = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : f.data[j-1];
                        if (tx !== expb) bad++;
                        if (j >= 1 && j <= 8 && (k % f.div) == f.div / 2) got[j-1] = tx;
                    end
                    if (!aborted) begin
                        chk("frame_data", got, f.data);
                        chk("frame_shape_errors", bad, 0);
                        frames_seen++;
                    end
                end
                mon_busy = 0;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus
    initial begin : stim
        logic [31:0] v;
        int e0, f0, bad, n;
        bus.addr = '0;
        bus.wdata = '0;
        bus.mem_write = 1'b0;
        m_reset();

        // 1: reset values
        #12;
        chk("rst_tx", tx, 1'b1);
        chk("rst_tx_idle", tx_idle, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rd(BASE + 4, "status_after_reset", v);
        chk("status_reset_const", v, 32'h4);
        rd(BASE + 8, "bauddiv_after_reset", v);
        chk("bauddiv_reset_const", v, 32'd434);
        rd(BASE + 12, "reserved_read", v);

        // 2: single 0x55 frame at div 4
        bus_write(BASE + 8, 32'd4);
        bus_write(BASE, 32'h55);
        e0 = wr_edge;
        wait_to(e0 + 1);
        chk("start_within_2", tx, 1'b0);
        wait_to(e0 + 40);
        chk("tx_idle_in_stop", tx_idle, m_idle(cyc));
        wait_to(e0 + 41);
        chk("tx_idle_after_stop", tx_idle, m_idle(cyc));
        wait_done();

        // 3: three back-to-back frames, count 2,1,0
        bus_write(BASE, 32'hA5);
        e0 = wr_edge;
        bus_write(BASE, 32'h00);
        bus_write(BASE, 32'hFF);
        rd(BASE + 4, "burst_status_a", v);
        chk("burst_count_2", (v >> 4) & 32'hF, 32'd2);
        wait_to(e0 + 40);
        rd(BASE + 4, "burst_status_b", v);
        chk("burst_count_1", (v >> 4) & 32'hF, 32'd1);
        wait_to(e0 + 80);
        rd(BASE + 4, "burst_status_c", v);
        chk("burst_count_0", (v >> 4) & 32'hF, 32'd0);
        wait_done();

        // 4: overflow with busy serialiser
        f0 = frames_seen;
        for (int i = 0; i < 10; i++) bus_write(BASE, 32'(i * 17 + 3));
        rd(BASE + 4, "ovf_status", v);
        chk("ovf_status_const", v, 32'h8B);
        bus_write(BASE + 4, 32'h8);
        rd(BASE + 4, "ovf_cleared", v);
        chk("ovf_cleared_const", v, 32'h83);
        wait_done();
        chk("ovf_frame_count", frames_seen - f0, 9);

        // 5: divider clamp and mid-frame divider change
        bus_write(BASE + 8, 32'd1);
        rd(BASE + 8, "div_clamp_1", v);
        chk("div_clamp_1_const", v, 32'd2);
        bus_write(BASE + 8, 32'd4);
        bus_write(BASE, 32'h3C);
        wait_to(wr_edge + 15);
        bus_write(BASE + 8, 32'd0);
        bus_write(BASE, 32'hC3);
        rd(BASE + 8, "div_clamp_0", v);
        chk("div_clamp_0_const", v, 32'd2);
        wait_done();

        // randomized traffic
        for (int r = 0; r < 6; r++) begin
            bus_write(BASE + 8, 32'($urandom_range(2, 6)));
            n = $urandom_range(4, 14);
            for (int i = 0; i < n; i++) begin
                bus_write(BASE, $urandom);
                if ($urandom_range(0, 2) == 0) rd(BASE + 4, "rand_status", v);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            rd(BASE + 4, "rand_status_end", v);
            bus_write(BASE + 4, 32'h8);
            rd(BASE + 4, "rand_status_clr", v);
            rd(BASE + 16 + 4 * $urandom_range(0, 3), "rand_outside", v);
            wait_done();
        end

        // 6: asynchronous reset in the middle of a data bit
        bus_write(BASE + 8, 32'd4);
        bus_write(BASE, 32'h0F);
        wait_to(wr_edge + 10);
        @(posedge clk);
        #2;
        reset = 1'b0;
        m_reset();
        #1;
        chk("async_reset_tx", tx, 1'b1);
        chk("async_reset_tx_idle", tx_idle, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        chk("no_residual_frame", bad, 0);
        rd(BASE + 4, "status_after_midreset", v);
        chk("status_midreset_const", v, 32'h4);

        // outside the window: no read data, no push
        bus_write(BASE + 16, 32'h77);
        rd(BASE + 16, "outside_read", v);
        chk("outside_read_const", v, 32'h0);
        rd(BASE + 4, "status_after_outside", v);
        chk("status_outside_const", v, 32'h4);
        repeat (20) @(negedge clk);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
